// File: rtl/uart_rx_fifo_monitor.sv
// uart_rx_fifo_monitor
//   UART receiver with programmable bit period, data bits, parity and stop
//   bits, followed by a first-word-fall-through receive FIFO with registered
//   head outputs for a valid/ready consumer.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rxd          asynchronous serial input, idles high
//   m_data       character at the FIFO head
//   m_parity_err head entry had a parity mismatch
//   m_frame_err  head entry had a stop bit sampled as 0
//   m_break      head entry is a break condition
//   m_valid      FIFO head is valid
//   m_ready      consumer accepts the head entry
//   fifo_count   FIFO occupancy after the current edge
//   overrun      sticky: a character was dropped on a full FIFO
//   overrun_clr  synchronous clear for overrun
//   rx_busy      receiver FSM is not idle
module uart_rx_fifo_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        rxd,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_parity_err,
  output logic                        m_frame_err,
  output logic                        m_break,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        overrun_clr,
  output logic                        rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = DATA_BITS + 3;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } state_t;

  // ------------------------------------------------------------------
  // Input synchroniser and falling-edge detect (preset to line idle)
  // ------------------------------------------------------------------
  logic sync1, rxs, rxs_prev, fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;

  // ------------------------------------------------------------------
  // Receiver FSM
  // ------------------------------------------------------------------
  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 stop_idx, stop_idx_n;
  logic                 push_req, push_n;
  logic [EW-1:0]        push_entry, entry_n;
  logic                 tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      stop_idx   <= 1'b0;
      push_req   <= 1'b0;
      push_entry <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      perr       <= perr_n;
      ferr       <= ferr_n;
      stop_idx   <= stop_idx_n;
      push_req   <= push_n;
      push_entry <= entry_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    perr_n     = perr;
    ferr_n     = ferr;
    stop_idx_n = stop_idx;
    push_n     = 1'b0;
    entry_n    = push_entry;
    tick       = (cnt == '0);

    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n    = S_START;
          cnt_n      = HALF_LOAD;
          idx_n      = '0;
          stop_idx_n = 1'b0;
          par_bit_n  = 1'b0;
          perr_n     = 1'b0;
          ferr_n     = 1'b0;
        end
      end

      S_START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rxs) begin
          state_n = S_IDLE;
        end else begin
          cnt_n   = FULL_LOAD;
          state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n = {rxs, shreg[DATA_BITS-1:1]};
          cnt_n   = FULL_LOAD;
          if (idx == LAST_IDX) begin
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          par_bit_n = rxs;
          perr_n    = (PARITY == 1) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
          cnt_n     = FULL_LOAD;
          state_n   = S_STOP;
        end
      end

      S_STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (!stop_idx && !rxs && (shreg == '0) &&
                     ((PARITY == 0) || !par_bit)) begin
          // All-zero character running into a low first stop bit: break.
          push_n  = 1'b1;
          entry_n = {1'b1, 1'b1, perr, shreg};
          state_n = S_BRKWAIT;
        end else if (stop_idx == LAST_STOP) begin
          // Push lands on the next edge, mid-stop-bit, so a following start
          // bit is caught from IDLE.
          push_n  = 1'b1;
          entry_n = {1'b0, ferr | ~rxs, perr, shreg};
          state_n = S_IDLE;
        end else begin
          ferr_n     = ferr | ~rxs;
          stop_idx_n = 1'b1;
          cnt_n      = FULL_LOAD;
        end
      end

      S_BRKWAIT: begin
        if (rxs) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign rx_busy = (state != S_IDLE);

  // ------------------------------------------------------------------
  // Receive FIFO
  // ------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count_after_pop;
  logic [EW-1:0] head;
  logic          pop, full, push_ok;

  assign pop             = m_valid & m_ready;
  assign full            = (fifo_count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok         = push_req & (~full | pop);
  assign rd_next         = rd_ptr + AW'(pop);
  assign count_after_pop = fifo_count - CW'(pop);
  assign head            = mem[rd_next];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // The head register is loaded only from entries already stored before
  // this edge, which gives the one-clock push-to-m_valid delay and lets a
  // pop present the following entry on the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_break      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_next;
      fifo_count <= count_after_pop + CW'(push_ok);
      m_valid    <= (count_after_pop != '0);
      if (count_after_pop != '0) begin
        {m_break, m_frame_err, m_parity_err, m_data} <= head;
      end else begin
        {m_break, m_frame_err, m_parity_err, m_data} <= '0;
      end
      if (push_req && !push_ok) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_monitor.sv
// Bench for uart_rx_fifo_monitor. Two instances: A is 8N1 depth 16,
// B is 7E1 depth 4. Expected entries go into per-instance queues; a monitor
// compares every accepted head entry against the queue front.
`timescale 1ns/1ps
module tb_uart_rx_fifo_monitor;

  localparam int CPB = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit abort    = 1'b0;

  // Instance A: defaults
  logic       rxd_a = 1'b1, m_ready_a = 1'b0, overrun_clr_a = 1'b0;
  logic [7:0] m_data_a;
  logic       m_parity_err_a, m_frame_err_a, m_break_a, m_valid_a;
  logic       overrun_a, rx_busy_a;
  logic [4:0] fifo_count_a;

  // Instance B: 7 data bits, even parity, depth 4
  logic       rxd_b = 1'b1, m_ready_b = 1'b0, overrun_clr_b = 1'b0;
  logic [6:0] m_data_b;
  logic       m_parity_err_b, m_frame_err_b, m_break_b, m_valid_b;
  logic       overrun_b, rx_busy_b;
  logic [2:0] fifo_count_b;

  uart_rx_fifo_monitor #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_a (
    .clock(clock), .reset_n(reset_n), .rxd(rxd_a),
    .m_data(m_data_a), .m_parity_err(m_parity_err_a), .m_frame_err(m_frame_err_a),
    .m_break(m_break_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .fifo_count(fifo_count_a), .overrun(overrun_a), .overrun_clr(overrun_clr_a),
    .rx_busy(rx_busy_a)
  );

  uart_rx_fifo_monitor #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .rxd(rxd_b),
    .m_data(m_data_b), .m_parity_err(m_parity_err_b), .m_frame_err(m_frame_err_b),
    .m_break(m_break_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .fifo_count(fifo_count_b), .overrun(overrun_b), .overrun_clr(overrun_clr_b),
    .rx_busy(rx_busy_b)
  );

  logic [10:0] exp_a[$];
  logic [9:0]  exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ent_a(input logic brk, input logic fe, input logic pe,
                                        input logic [7:0] d);
    return {brk, fe, pe, d};
  endfunction

  function automatic logic [9:0] ent_b(input logic brk, input logic fe, input logic pe,
                                       input logic [6:0] d);
    return {brk, fe, pe, d};
  endfunction

  // Scoreboard monitor: compares each accepted head entry.
  initial begin
    logic [10:0] ea;
    logic [9:0]  eb;
    forever begin
      @(negedge clock);
      #1;
      if (reset_n && m_valid_a && m_ready_a) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_a_extra: got 0x%0h, expected no entry",
                   {m_break_a, m_frame_err_a, m_parity_err_a, m_data_a});
        end else begin
          ea = exp_a.pop_front();
          check("sb_a", {m_break_a, m_frame_err_a, m_parity_err_a, m_data_a}, ea);
        end
      end
      if (reset_n && m_valid_b && m_ready_b) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_b_extra: got 0x%0h, expected no entry",
                   {m_break_b, m_frame_err_b, m_parity_err_b, m_data_b});
        end else begin
          eb = exp_b.pop_front();
          check("sb_b", {m_break_b, m_frame_err_b, m_parity_err_b, m_data_b}, eb);
        end
      end
    end
  end

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (abort) begin
      set_line(sel, 1'b1);
      return;
    end
    set_line(sel, v);
    for (int i = 0; i < CPB; i++) begin
      @(negedge clock);
      if (abort) break;
    end
    if (abort) set_line(sel, 1'b1);
  endtask

  task automatic send_char(input bit sel, input logic [8:0] d, input int nbits,
                           input bit has_par, input logic pbit, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, pbit);
    drive_bit(sel, stop);
  endtask

  task automatic wait_busy(input bit sel, input logic lvl, input int max_cyc,
                           input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if ((sel ? rx_busy_b : rx_busy_a) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [8:0] v;
    bit         seen;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    check("rst_valid_a", m_valid_a, 0);
    check("rst_count_a", fifo_count_a, 0);
    check("rst_flags_a", {overrun_a, rx_busy_a, m_break_a, m_frame_err_a, m_parity_err_a, m_data_a}, 0);
    check("rst_state_b", {m_valid_b, fifo_count_b, overrun_b, rx_busy_b}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // ---------------- 8N1 0x55, latency, single pop ----------------
    exp_a.push_back(ent_a(0, 0, 0, 8'h55));
    fork
      send_char(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b1);
    join_none
    wait_busy(1'b0, 1'b1, 50, "busy_rise_55");
    wait_busy(1'b0, 1'b0, 400, "busy_fall_55");
    check("lat0_valid", m_valid_a, 0);
    @(negedge clock);
    check("lat1_count", fifo_count_a, 1);
    check("lat1_valid", m_valid_a, 0);
    @(negedge clock);
    check("lat2_valid", m_valid_a, 1);
    check("lat2_data", m_data_a, 8'h55);
    repeat (8) @(negedge clock);
    m_ready_a = 1'b1;
    @(negedge clock);
    m_ready_a = 1'b0;
    @(negedge clock);
    check("pop_count_a", fifo_count_a, 0);
    check("pop_valid_a", m_valid_a, 0);

    // ---------------- 3-clock glitch: false start ----------------
    rxd_a = 1'b0;
    repeat (3) @(negedge clock);
    rxd_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (rx_busy_a) seen = 1'b1;
    end
    check("glitch_busy_pulse", seen, 1);
    check("glitch_busy_end", rx_busy_a, 0);
    check("glitch_count", fifo_count_a, 0);

    // ---------------- frame error then break ----------------
    m_ready_a = 1'b1;
    exp_a.push_back(ent_a(0, 1, 0, 8'hA3));
    send_char(1'b0, 9'h0A3, 8, 1'b0, 1'b0, 1'b0);
    rxd_a = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    exp_a.push_back(ent_a(1, 1, 0, 8'h00));
    rxd_a = 1'b0;
    repeat (30 * CPB) @(negedge clock);
    check("brk_held_busy", rx_busy_a, 1);
    check("brk_one_entry", exp_a.size(), 0);
    rxd_a = 1'b1;
    repeat (8) @(negedge clock);
    check("brk_release_busy", rx_busy_a, 0);
    check("brk_count", fifo_count_a, 0);
    m_ready_a = 1'b0;

    // ---------------- B: even parity, 7 data bits ----------------
    m_ready_b = 1'b1;
    exp_b.push_back(ent_b(0, 0, 0, 7'h41));
    send_char(1'b1, 9'h041, 7, 1'b1, 1'b0, 1'b1);
    exp_b.push_back(ent_b(0, 0, 1, 7'h41));
    send_char(1'b1, 9'h041, 7, 1'b1, 1'b1, 1'b1);
    repeat (6) @(negedge clock);
    check("par_drained", exp_b.size(), 0);
    m_ready_b = 1'b0;
    repeat (4) @(negedge clock);

    // ---------------- B: overrun with depth 4 ----------------
    for (int i = 1; i <= 4; i++) exp_b.push_back(ent_b(0, 0, 0, 7'(i)));
    for (int i = 1; i <= 6; i++) begin
      v = 9'(i);
      send_char(1'b1, v, 7, 1'b1, ^v[6:0], 1'b1);
    end
    repeat (4) @(negedge clock);
    check("ovr_count", fifo_count_b, 4);
    check("ovr_flag", overrun_b, 1);
    overrun_clr_b = 1'b1;
    @(negedge clock);
    overrun_clr_b = 1'b0;
    @(negedge clock);
    check("ovr_clr", overrun_b, 0);

    // Full FIFO: pop lines up with the push of 0x07
    exp_b.push_back(ent_b(0, 0, 0, 7'h07));
    fork
      send_char(1'b1, 9'h007, 7, 1'b1, 1'b1, 1'b1);
    join_none
    wait_busy(1'b1, 1'b1, 50, "busy_rise_07");
    wait_busy(1'b1, 1'b0, 400, "busy_fall_07");
    m_ready_b = 1'b1;
    @(negedge clock);
    m_ready_b = 1'b0;
    @(negedge clock);
    check("fullpp_overrun", overrun_b, 0);
    check("fullpp_count", fifo_count_b, 4);
    repeat (12) @(negedge clock);
    m_ready_b = 1'b1;
    repeat (12) @(negedge clock);
    m_ready_b = 1'b0;
    check("drain_b_queue", exp_b.size(), 0);
    check("drain_b_count", fifo_count_b, 0);

    // ---------------- reset mid-character ----------------
    send_char(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    check("pre_rst_count", fifo_count_a, 1);
    check("pre_rst_valid", m_valid_a, 1);
    fork
      send_char(1'b0, 9'h0F0, 8, 1'b0, 1'b0, 1'b1);
    join_none
    repeat (4 * CPB) @(negedge clock);
    check("mid_data_busy", rx_busy_a, 1);
    reset_n = 1'b0;
    #1;
    check("arst_valid", m_valid_a, 0);
    check("arst_count", fifo_count_a, 0);
    check("arst_busy", rx_busy_a, 0);
    check("arst_head", {m_break_a, m_frame_err_a, m_parity_err_a, m_data_a}, 0);
    abort = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    abort = 1'b0;
    rxd_a = 1'b1;
    m_ready_a = 1'b1;
    exp_a.push_back(ent_a(0, 0, 0, 8'h3C));
    send_char(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clock);
    check("post_rst_queue", exp_a.size(), 0);
    check("post_rst_overrun", overrun_a, 0);
    check("post_rst_count", fifo_count_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
